zeroriscy_irq_arbiter: RTL and testbench
========================================

// Module: zeroriscy_irq_arbiter
// PURPOSE
//  Collects up to 32 external interrupt lines and picks one pending, enabled line.
//  Presents it as a single level request plus a 5-bit id. Sits directly upstream of the
//  interrupt controller, driving its irq_i/irq_id_i. Clears edge-latched pending state on
//  the core's acknowledge.
// PARAMETERS
//  NUM_IRQ      32            number of interrupt lines, 1..32
//  SYNC_STAGES  2             synchronizer depth on irq_lines_i, 1..3
//  EDGE_MASK    32'h0         bit i=1: line i rising-edge latched; 0: level
//  EN_RESET     32'hFFFF_FFFF enable register reset value
// PORTS
//  clk            in   1        core clock
//  rst            in   1        async reset, active-high
//  irq_lines_i    in   NUM_IRQ  raw interrupt lines, asynchronous to clk
//  cfg_we_i       in   1        write enable register this cycle
//  cfg_wdata_i    in   NUM_IRQ  new enable register value
//  irq_ack_i      in   1        core acknowledges interrupt irq_ack_id_i (1-cycle pulse)
//  irq_ack_id_i   in   5        id being acknowledged
//  irq_o          out  1        request to interrupt controller (level)
//  irq_id_o       out  5        selected line id, valid when irq_o=1
//  en_o           out  NUM_IRQ  enable register readback
//  pending_o      out  NUM_IRQ  pending vector (mip-style visibility)
// BEHAVIOUR
//  - Reset: sync flops, edge history, pending_q, irq_o, irq_id_o=0; en_q=EN_RESET[NUM_IRQ-1:0].
//  - Sync: each line passes SYNC_STAGES flops -> s[i]. Edge detect uses s[i] & ~s_d[i].
//  - Edge lines: pending_q[i] set on rising edge of s[i]. Cleared when irq_ack_i && irq_ack_id_i==i.
//    Set and clear in the same cycle -> set wins (new edge is not lost).
//  - Level lines: pending[i]=s[i], never latched; ack has no effect.
//  - en_q <= cfg_wdata_i when cfg_we_i. A disabled line still latches pending; it just cannot be selected.
//  - active = pending & en_q. Selection is combinational from active.
//    Registered outputs: irq_o <= |active; irq_id_o <= selected id (0 if none).
//  - Latency: line change -> irq_o = SYNC_STAGES+1 cycles (edge and level alike).
//  - Ack effect visible on irq_o/irq_id_o one cycle after the ack pulse.
//  - Fixed priority: lowest-index active line wins.
//  - irq_ack_id_i >= NUM_IRQ, or ack of a level line: ignored, no state change.
//  - Ack for a line that is not pending: no effect.
//  - All lines active: id resolves per priority rule; no starvation guarantee in fixed mode.
//  - NUM_IRQ<32: unused id values never produced; irq_id_o always 5 bits.
//  - Reset mid-operation: everything returns to reset values immediately, including an in-flight request.
// CONFIGURATION
//  ZERORISCY_IRQ_ROUND_ROBIN_EN
//   defined:   rotating priority. A pointer (5b, reset 0) is set to ack_id+1 (mod NUM_IRQ) on each
//              accepted ack. Search starts at the pointer and wraps.
//   undefined: fixed lowest-index priority; pointer logic absent.
// STRUCTURE
//  - zeroriscy_defines gains: IRQ_ID_W=5, IRQ_MAX=32, typedef logic [IRQ_ID_W-1:0] irq_id_t.
//  - Sub-module zeroriscy_irq_prio_sel: find-first-set over NUM_IRQ bits with a start index input.
//    Outputs found + id. Top ties start to 0 when round-robin is disabled.
// TESTING
//  1 Reset, then level line 3 high -> irq_o=1, irq_id_o=3 after SYNC_STAGES+1 cycles;
//    line low -> irq_o=0 after same latency.
//  2 Edge lines 5,9 pulse together -> irq_id_o=5; ack id 5 -> next cycle irq_id_o=9;
//    ack 9 -> irq_o=0.
//  3 Edge line 7: new rising edge in the same cycle as ack id 7 -> pending_o[7] stays 1, irq_o stays 1.
//  4 cfg_we_i clears en bit 2 while line 2 pending -> irq_o drops next cycle, pending_o[2]=1;
//    re-enable -> irq_id_o=2.
//  5 Ack id 31 with NUM_IRQ=8, and ack of a level line -> no state change.
//    Assert rst mid-request -> irq_o=0 at once.
//  6 ZERORISCY_IRQ_ROUND_ROBIN_EN, edge lines 1,4 re-pulsed after each ack ->
//    ids alternate 1,4,1,4; undefined -> always 1.

Source files
------------

// File: rtl/zeroriscy_irq_arbiter_pkg.sv
// Shared types and constants for the interrupt arbiter slice.
// Holds the interrupt-id width, the maximum line count and the id type
// that the arbiter, its interface and its priority selector all share.
package zeroriscy_irq_arbiter_pkg;

  localparam int unsigned IRQ_ID_W = 5;
  localparam int unsigned IRQ_MAX  = 32;

  typedef logic [IRQ_ID_W-1:0] irq_id_t;

endpackage

// File: rtl/zeroriscy_irq_arbiter_if.sv
// Interface bundling the raw interrupt lines, the enable-register write port,
// the acknowledge handshake and the request/readback outputs of the arbiter.
// slave  : the arbiter side.
// master : the side that drives the lines and acks and consumes the request.
interface zeroriscy_irq_arbiter_if #(
  parameter int unsigned NUM_IRQ = 32
);
  import zeroriscy_irq_arbiter_pkg::*;

  logic [NUM_IRQ-1:0] irq_lines_i;
  logic               cfg_we_i;
  logic [NUM_IRQ-1:0] cfg_wdata_i;
  logic               irq_ack_i;
  irq_id_t            irq_ack_id_i;
  logic               irq_o;
  irq_id_t            irq_id_o;
  logic [NUM_IRQ-1:0] en_o;
  logic [NUM_IRQ-1:0] pending_o;

  modport slave (
    input  irq_lines_i, cfg_we_i, cfg_wdata_i, irq_ack_i, irq_ack_id_i,
    output irq_o, irq_id_o, en_o, pending_o
  );

  modport master (
    output irq_lines_i, cfg_we_i, cfg_wdata_i, irq_ack_i, irq_ack_id_i,
    input  irq_o, irq_id_o, en_o, pending_o
  );

endinterface

// File: rtl/zeroriscy_irq_prio_sel.sv
// Find-first-set over NUM_IRQ request bits, starting the search at index
// 'start' and wrapping around. With start tied to 0 this is a plain
// lowest-index-wins priority encoder. 'start' must be below NUM_IRQ.
module zeroriscy_irq_prio_sel
  import zeroriscy_irq_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IRQ = 32
) (
  input  logic [NUM_IRQ-1:0] req,
  input  irq_id_t            start,
  output logic               found,
  output irq_id_t            id
);

  localparam logic [IRQ_ID_W:0] NUM_W = (IRQ_ID_W+1)'(NUM_IRQ);

  logic [NUM_IRQ-1:0] rot;
  irq_id_t            pos;
  logic [IRQ_ID_W:0]  sum;

  // Rotate so that bit 'start' lands at position 0; the wrap comes from the doubled vector.
  assign rot = NUM_IRQ'({req, req} >> start);

  // Lowest set bit of the rotated vector, then map the offset back to a line index.
  always_comb begin
    found = 1'b0;
    pos   = '0;
    sum   = '0;
    for (int k = NUM_IRQ - 1; k >= 0; k--) begin
      if (rot[k]) begin
        found = 1'b1;
        pos   = irq_id_t'(k);
      end
    end
    sum = {1'b0, start} + {1'b0, pos};
    if (sum >= NUM_W) begin
      sum = sum - NUM_W;
    end
    id = found ? sum[IRQ_ID_W-1:0] : '0;
  end

endmodule

// File: rtl/zeroriscy_irq_arbiter.sv
// Interrupt arbiter: synchronizes up to 32 external lines, latches rising
// edges on edge-configured lines, masks with an enable register and presents
// one registered request plus id to the interrupt controller.
// Optional feature: define ZERORISCY_IRQ_ROUND_ROBIN_EN for rotating priority
// (search restarts just after the last acknowledged line); otherwise the
// lowest-index active line always wins.
// The registered request is computed from the next-cycle pending/enable state,
// so an ack or enable write shows on irq_o/irq_id_o right after its clock edge
// and a line change reaches irq_o SYNC_STAGES+1 cycles later for both kinds.
module zeroriscy_irq_arbiter
  import zeroriscy_irq_arbiter_pkg::*;
#(
  parameter int unsigned NUM_IRQ     = 32,
  parameter int unsigned SYNC_STAGES = 2,
  parameter logic [31:0] EDGE_MASK   = 32'h0,
  parameter logic [31:0] EN_RESET    = 32'hFFFF_FFFF
) (
  input logic                   clk,
  input logic                   rst,
  zeroriscy_irq_arbiter_if.slave bus
);

  localparam logic [NUM_IRQ-1:0] EDGE    = EDGE_MASK[NUM_IRQ-1:0];
  localparam logic [NUM_IRQ-1:0] EN_INIT = EN_RESET[NUM_IRQ-1:0];

  logic [NUM_IRQ-1:0] sync_q [SYNC_STAGES];
  logic [NUM_IRQ-1:0] s;
  logic [NUM_IRQ-1:0] s_d_q;
  logic [NUM_IRQ-1:0] rise;
  logic [NUM_IRQ-1:0] ack_hit;
  logic [NUM_IRQ-1:0] clr;
  logic [NUM_IRQ-1:0] pend_q;
  logic [NUM_IRQ-1:0] pend_next;
  logic [NUM_IRQ-1:0] pend_sel;
  logic [NUM_IRQ-1:0] en_q;
  logic [NUM_IRQ-1:0] en_next;
  logic [NUM_IRQ-1:0] active;
  logic               ack_ok;
  irq_id_t            start;
  logic               sel_found;
  irq_id_t            sel_id;
  logic               irq_q;
  irq_id_t            irq_id_q;

  // Synchronizer chain: stage 0 samples the raw lines, later stages shift.
  for (genvar gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
    if (gi == 0) begin : g_first
      // First synchronizer stage captures the asynchronous lines.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q[gi] <= '0;
        else     sync_q[gi] <= bus.irq_lines_i;
      end
    end else begin : g_rest
      // Subsequent stages resolve metastability.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q[gi] <= '0;
        else     sync_q[gi] <= sync_q[gi-1];
      end
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Per-line decode of the acknowledge id; ids at or above NUM_IRQ match nothing.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
    assign ack_hit[gi] = bus.irq_ack_i && (bus.irq_ack_id_i == irq_id_t'(gi));
  end

  assign rise      = s & ~s_d_q & EDGE;
  assign clr       = ack_hit & EDGE & pend_q;
  assign ack_ok    = |clr;
  // A fresh edge beats a same-cycle clear so no event is lost.
  assign pend_next = (pend_q & ~clr) | rise;
  assign pend_sel  = (pend_next & EDGE) | (s & ~EDGE);
  assign en_next   = bus.cfg_we_i ? bus.cfg_wdata_i : en_q;
  assign active    = pend_sel & en_next;

`ifdef ZERORISCY_IRQ_ROUND_ROBIN_EN
  irq_id_t ptr_q;
  irq_id_t ptr_next;

  // Next search start: one past the line just acknowledged, wrapping at NUM_IRQ.
  always_comb begin
    ptr_next = ptr_q;
    if (ack_ok) begin
      if (bus.irq_ack_id_i == irq_id_t'(NUM_IRQ - 1)) ptr_next = '0;
      else                                            ptr_next = bus.irq_ack_id_i + 1'b1;
    end
  end

  // Rotating-priority pointer register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) ptr_q <= '0;
    else     ptr_q <= ptr_next;
  end

  assign start = ptr_next;
`else
  assign start = '0;
`endif

  zeroriscy_irq_prio_sel #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_sel (
    .req   (active),
    .start (start),
    .found (sel_found),
    .id    (sel_id)
  );

  // Edge history, pending latches, enable register and the registered request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_d_q    <= '0;
      pend_q   <= '0;
      en_q     <= EN_INIT;
      irq_q    <= 1'b0;
      irq_id_q <= '0;
    end else begin
      s_d_q    <= s;
      pend_q   <= pend_next & EDGE;
      en_q     <= en_next;
      irq_q    <= sel_found;
      irq_id_q <= sel_found ? sel_id : '0;
    end
  end

  assign bus.irq_o     = irq_q;
  assign bus.irq_id_o  = irq_id_q;
  assign bus.en_o      = en_q;
  assign bus.pending_o = (pend_q & EDGE) | (s & ~EDGE);

endmodule

// File: tb/tb_zeroriscy_irq_arbiter.sv
// Self-checking bench for zeroriscy_irq_arbiter (NUM_IRQ=12, edge lines 1,4,5,7,9).
// Expected request/id pairs are queued when stimulus is applied and compared
// once the arbiter's latency has elapsed.
module tb_zeroriscy_irq_arbiter;

  localparam int unsigned N    = 12;
  localparam int unsigned SYNC = 2;
  localparam int          LAT  = SYNC + 1;
  localparam logic [31:0] EDGE_MASK = 32'h0000_02B2;
`ifdef ZERORISCY_IRQ_ROUND_ROBIN_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  zeroriscy_irq_arbiter_if #(.NUM_IRQ(N)) bus ();

  zeroriscy_irq_arbiter #(
    .NUM_IRQ     (N),
    .SYNC_STAGES (SYNC),
    .EDGE_MASK   (EDGE_MASK),
    .EN_RESET    (32'hFFFF_FFFF)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic       irq;
    logic [4:0] id;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic sb_push(input string tag, input logic irq, input int id);
    exp_t e;
    e.tag = tag;
    e.irq = irq;
    e.id  = 5'(id);
    sb_q.push_back(e);
  endtask

  task automatic sb_compare();
    exp_t e;
    check_val("sb_depth", 32'(sb_q.size()), 32'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check_val({e.tag, "_irq"}, 32'(bus.irq_o), 32'(e.irq));
      check_val({e.tag, "_id"}, 32'(bus.irq_id_o), 32'(e.id));
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse(input int line);
    bus.irq_lines_i[line] = 1'b1;
    step(1);
    bus.irq_lines_i[line] = 1'b0;
  endtask

  task automatic ack(input int id);
    bus.irq_ack_i    = 1'b1;
    bus.irq_ack_id_i = 5'(id);
    step(1);
    bus.irq_ack_i    = 1'b0;
  endtask

  int cur;

  initial begin
    rst              = 1'b1;
    bus.irq_lines_i  = '0;
    bus.cfg_we_i     = 1'b0;
    bus.cfg_wdata_i  = '0;
    bus.irq_ack_i    = 1'b0;
    bus.irq_ack_id_i = '0;
    step(2);
    rst = 1'b0;
    step(1);

    // reset state
    check_val("rst_irq", 32'(bus.irq_o), 32'd0);
    check_val("rst_id", 32'(bus.irq_id_o), 32'd0);
    check_val("rst_pending", 32'(bus.pending_o), 32'd0);
    check_val("rst_en", 32'(bus.en_o), 32'hFFF);

    // 1: level line 3 high then low, exact latency
    bus.irq_lines_i[3] = 1'b1;
    step(LAT - 1);
    check_val("t1_early", 32'(bus.irq_o), 32'd0);
    step(1);
    sb_push("t1_on", 1'b1, 3);
    sb_compare();
    check_val("t1_pend3", 32'(bus.pending_o[3]), 32'd1);
    bus.irq_lines_i[3] = 1'b0;
    step(LAT - 1);
    check_val("t1_hold", 32'(bus.irq_o), 32'd1);
    step(1);
    sb_push("t1_off", 1'b0, 0);
    sb_compare();

    // 2: edge lines 5 and 9 together, acked in priority order
    bus.irq_lines_i[5] = 1'b1;
    bus.irq_lines_i[9] = 1'b1;
    step(1);
    bus.irq_lines_i = '0;
    step(LAT - 1);
    sb_push("t2_first", 1'b1, 5);
    sb_compare();
    check_val("t2_pend", 32'(bus.pending_o), 32'h220);
    ack(5);
    sb_push("t2_after5", 1'b1, 9);
    sb_compare();
    ack(9);
    sb_push("t2_after9", 1'b0, 0);
    sb_compare();
    check_val("t2_pend_clr", 32'(bus.pending_o), 32'd0);

    // 3: new edge on line 7 coincides with its ack: set wins
    pulse(7);
    step(LAT - 1);
    sb_push("t3_on", 1'b1, 7);
    sb_compare();
    bus.irq_lines_i[7] = 1'b1;
    step(1);
    bus.irq_lines_i[7] = 1'b0;
    step(1);
    ack(7);
    check_val("t3_pend7", 32'(bus.pending_o[7]), 32'd1);
    sb_push("t3_setwins", 1'b1, 7);
    sb_compare();
    ack(7);
    sb_push("t3_clr", 1'b0, 0);
    sb_compare();

    // 4: disable and re-enable a pending line
    bus.irq_lines_i[2] = 1'b1;
    step(LAT);
    sb_push("t4_on", 1'b1, 2);
    sb_compare();
    bus.cfg_we_i    = 1'b1;
    bus.cfg_wdata_i = 12'hFFB;
    step(1);
    bus.cfg_we_i = 1'b0;
    sb_push("t4_masked", 1'b0, 0);
    sb_compare();
    check_val("t4_pend2", 32'(bus.pending_o[2]), 32'd1);
    check_val("t4_en", 32'(bus.en_o), 32'hFFB);
    bus.cfg_we_i    = 1'b1;
    bus.cfg_wdata_i = 12'hFFF;
    step(1);
    bus.cfg_we_i = 1'b0;
    sb_push("t4_reen", 1'b1, 2);
    sb_compare();
    bus.irq_lines_i[2] = 1'b0;
    step(LAT);
    sb_push("t4_off", 1'b0, 0);
    sb_compare();

    // 5: ignored acks, then reset mid-request
    pulse(5);
    step(LAT - 1);
    sb_push("t5_on", 1'b1, 5);
    sb_compare();
    ack(31);
    sb_push("t5_ack31", 1'b1, 5);
    sb_compare();
    check_val("t5_pend_31", 32'(bus.pending_o), 32'h020);
    bus.irq_lines_i[3] = 1'b1;
    step(LAT);
    sb_push("t5_lvl3", 1'b1, 3);
    sb_compare();
    ack(3);
    sb_push("t5_ack3", 1'b1, 3);
    sb_compare();
    check_val("t5_pend_ack3", 32'(bus.pending_o), 32'h028);
    ack(7);
    check_val("t5_pend_ack7", 32'(bus.pending_o), 32'h028);
    rst = 1'b1;
    #1;
    check_val("t5_rst_irq", 32'(bus.irq_o), 32'd0);
    check_val("t5_rst_id", 32'(bus.irq_id_o), 32'd0);
    check_val("t5_rst_pend", 32'(bus.pending_o), 32'd0);
    bus.irq_lines_i = '0;
    step(2);
    rst = 1'b0;
    step(LAT);
    check_val("t5_post_rst", 32'(bus.irq_o), 32'd0);

    // 6: edge lines 1 and 4, winner re-pulsed after each ack
    bus.irq_lines_i[1] = 1'b1;
    bus.irq_lines_i[4] = 1'b1;
    step(1);
    bus.irq_lines_i = '0;
    step(LAT - 1);
    for (int i = 0; i < 4; i++) begin
      cur = (RR && (i % 2 == 1)) ? 4 : 1;
      sb_push($sformatf("t6_turn%0d", i), 1'b1, cur);
      sb_compare();
      ack(cur);
      pulse(cur);
      step(LAT - 1);
    end
    ack(1);
    ack(4);
    sb_push("t6_clr", 1'b0, 0);
    sb_compare();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
